// File: rtl/vec_fifo_sched.sv
// Purpose: write-beat/vector commit counter plus read FSM that replays each vector replay_cfg+1 times.
// Latency: commit registered, one IDLE cycle, then reads; each release costs one IDLE bubble.
// Backpressure: wr_rdy drops when Depth vectors are committed; reads advance only on rd_req.
module vec_fifo_sched #(
    parameter int Depth        = 4,
    parameter int WritesPerVec = 4,
    parameter int ReadsPerVec  = 2,
    parameter int ReplayBits   = 4
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           wr_req,
    output logic                           wr_rdy,
    output logic                           fifo_wr_en,
    input  logic                           rd_req,
    output logic                           rd_valid,
    output logic                           fifo_rd_en,
    output logic                           fifo_ptr_rst,
    input  logic [ReplayBits-1:0]          replay_cfg,
    output logic [$clog2(Depth+1)-1:0]     occupancy,
    output logic                           vec_done
);

    localparam int WBW = (WritesPerVec > 1) ? $clog2(WritesPerVec) : 1;
    localparam int RBW = (ReadsPerVec > 1) ? $clog2(ReadsPerVec) : 1;
    localparam int OW  = $clog2(Depth + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        REWIND = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [WBW-1:0]        wr_beat;
    logic [RBW-1:0]        rd_beat;
    logic [ReplayBits-1:0] passes_left;
    logic                  out_en;
    logic                  wr_last;
    logic                  rd_last;
    logic                  commit;
    logic                  release_vec;
    logic                  start_vec;

    // out_en keeps wr_rdy low while in reset and raises it on the first edge afterwards.
    assign wr_last    = (wr_beat == WBW'(WritesPerVec - 1));
    assign rd_last    = (rd_beat == RBW'(ReadsPerVec - 1));
    assign wr_rdy     = out_en && (occupancy < OW'(Depth));
    assign fifo_wr_en = wr_req && wr_rdy;
    assign commit     = fifo_wr_en && wr_last;

    // Next-state and read-side outputs; all outputs come from state/counters and rd_req only.
    always_comb begin
        state_nxt    = state;
        rd_valid     = 1'b0;
        fifo_rd_en   = 1'b0;
        fifo_ptr_rst = 1'b0;
        vec_done     = 1'b0;
        release_vec  = 1'b0;
        start_vec    = 1'b0;
        case (state)
            IDLE: begin
                if (occupancy != '0) begin
                    start_vec = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: begin
                rd_valid   = 1'b1;
                fifo_rd_en = rd_req;
                if (rd_req && rd_last) begin
                    if (passes_left != '0) begin
                        state_nxt = REWIND;
                    end else begin
                        release_vec = 1'b1;
                        vec_done    = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
            end
            REWIND: begin
                fifo_ptr_rst = 1'b1;
                state_nxt    = READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Read beat and pass bookkeeping; replay_cfg is sampled only when a vector starts.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_beat     <= '0;
            passes_left <= '0;
        end else if (start_vec) begin
            rd_beat     <= '0;
            passes_left <= replay_cfg;
        end else if (state == REWIND) begin
            rd_beat <= '0;
        end else if (state == READ && rd_req) begin
            if (rd_last) begin
                rd_beat <= '0;
                if (passes_left != '0) begin
                    passes_left <= passes_left - ReplayBits'(1);
                end
            end else begin
                rd_beat <= rd_beat + RBW'(1);
            end
        end
    end

    // Write beat counter, wrapping on the beat that completes a vector.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_beat <= '0;
        end else if (fifo_wr_en) begin
            wr_beat <= wr_last ? '0 : wr_beat + WBW'(1);
        end
    end

    // Occupancy: a commit and a release in the same cycle cancel out.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            occupancy <= '0;
        end else begin
            case ({commit, release_vec})
                2'b10:   occupancy <= occupancy + OW'(1);
                2'b01:   occupancy <= occupancy - OW'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Output enable held low through reset, set from the first clock edge onwards.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vec_fifo_sched.sv
// Directed bench for vec_fifo_sched with Depth=2, WritesPerVec=4, ReadsPerVec=2.
// Inputs change 1ns after the rising edge; outputs are sampled 1-2ns later, well before the falling edge.
module tb_vec_fifo_sched;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       wr_req;
    logic       wr_rdy;
    logic       fifo_wr_en;
    logic       rd_req;
    logic       rd_valid;
    logic       fifo_rd_en;
    logic       fifo_ptr_rst;
    logic [3:0] replay_cfg;
    logic [1:0] occupancy;
    logic       vec_done;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_fifo_sched #(
        .Depth(2), .WritesPerVec(4), .ReadsPerVec(2), .ReplayBits(4)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .wr_req(wr_req), .wr_rdy(wr_rdy), .fifo_wr_en(fifo_wr_en),
        .rd_req(rd_req), .rd_valid(rd_valid), .fifo_rd_en(fifo_rd_en),
        .fifo_ptr_rst(fifo_ptr_rst), .replay_cfg(replay_cfg),
        .occupancy(occupancy), .vec_done(vec_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] exp_v;
        logic [8:0] exp_p;
        logic [8:0] exp_d;
        int         beats;
        int         ptrs;
        int         beats_at_done;
        logic       done_seen;

        // ---------------- reset state ----------------
        rst_in = 1'b1; wr_req = 1'b1; rd_req = 1'b1; replay_cfg = 4'd0;
        #2;
        chk("rst_wr_rdy", wr_rdy, 0);
        chk("rst_fifo_wr_en", fifo_wr_en, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_fifo_rd_en", fifo_rd_en, 0);
        chk("rst_ptr_rst", fifo_ptr_rst, 0);
        chk("rst_vec_done", vec_done, 0);
        chk("rst_occ", occupancy, 0);
        wr_req = 1'b0; rd_req = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        tick;
        chk("post_rst_wr_rdy", wr_rdy, 1);

        // ---------------- basic vector ----------------
        rd_req = 1'b1;
        wr_req = 1'b1;
        #1 chk("basic_wr_en", fifo_wr_en, 1);
        repeat (4) tick;
        wr_req = 1'b0;
        #1;
        chk("basic_occ1", occupancy, 1);
        chk("basic_idle_rv", rd_valid, 0);
        tick;
        chk("basic_rv0", rd_valid, 1);
        chk("basic_rdEn0", fifo_rd_en, 1);
        chk("basic_done0", vec_done, 0);
        tick;
        chk("basic_rv1", rd_valid, 1);
        chk("basic_done1", vec_done, 1);
        tick;
        chk("basic_occ0", occupancy, 0);
        chk("basic_idle_after", rd_valid, 0);
        chk("basic_done_clr", vec_done, 0);

        // ---------------- full ----------------
        rd_req = 1'b0;
        wr_req = 1'b1;
        repeat (8) tick;
        chk("full_occ2", occupancy, 2);
        chk("full_wr_rdy", wr_rdy, 0);
        chk("full_9th_wr_en", fifo_wr_en, 0);
        tick;
        chk("full_occ_hold", occupancy, 2);
        wr_req = 1'b0;
        rd_req = 1'b1;
        tick;
        chk("full_done", vec_done, 1);
        chk("full_rdy_same", wr_rdy, 0);
        tick;
        chk("full_occ_after_rel", occupancy, 1);
        chk("full_rdy_back", wr_rdy, 1);
        repeat (3) tick;
        chk("full_drain_occ", occupancy, 0);

        // ---------------- replay x3 passes ----------------
        replay_cfg = 4'd2;
        wr_req = 1'b1;
        repeat (4) tick;
        wr_req = 1'b0;
        exp_v = 9'b011011011;
        exp_p = 9'b000100100;
        exp_d = 9'b010000000;
        beats = 0; ptrs = 0; beats_at_done = 0;
        for (int i = 0; i < 9; i++) begin
            tick;
            chk($sformatf("rep_rv_%0d", i), rd_valid, exp_v[i]);
            chk($sformatf("rep_ptr_%0d", i), fifo_ptr_rst, exp_p[i]);
            chk($sformatf("rep_done_%0d", i), vec_done, exp_d[i]);
            if (rd_valid && rd_req) beats++;
            if (fifo_ptr_rst) ptrs++;
            if (vec_done) beats_at_done = beats;
        end
        chk("rep_ptr_count", ptrs, 2);
        chk("rep_beats_at_done", beats_at_done, 6);
        chk("rep_occ0", occupancy, 0);
        replay_cfg = 4'd0;

        // ---------------- simultaneous commit + release ----------------
        rd_req = 1'b0;
        wr_req = 1'b1;
        repeat (4) tick;
        wr_req = 1'b0;
        tick;
        wr_req = 1'b1;
        repeat (3) tick;
        wr_req = 1'b0;
        rd_req = 1'b1;
        tick;
        wr_req = 1'b1;
        #1;
        chk("sim_done", vec_done, 1);
        chk("sim_wr_en", fifo_wr_en, 1);
        tick;
        wr_req = 1'b0;
        #1;
        chk("sim_occ1", occupancy, 1);
        chk("sim_idle", rd_valid, 0);
        tick;
        chk("sim_read_v2", rd_valid, 1);
        tick;
        chk("sim_done_v2", vec_done, 1);
        tick;
        chk("sim_occ0", occupancy, 0);

        // ---------------- reset mid-operation ----------------
        rd_req = 1'b0;
        wr_req = 1'b1;
        repeat (4) tick;
        wr_req = 1'b0;
        tick;
        wr_req = 1'b1;
        repeat (2) tick;
        wr_req = 1'b0;
        rd_req = 1'b1;
        tick;
        rst_in = 1'b1;
        wr_req = 1'b1;
        #1;
        chk("mrst_rd_valid", rd_valid, 0);
        chk("mrst_rd_en", fifo_rd_en, 0);
        chk("mrst_done", vec_done, 0);
        chk("mrst_occ", occupancy, 0);
        chk("mrst_wr_rdy", wr_rdy, 0);
        chk("mrst_wr_en", fifo_wr_en, 0);
        wr_req = 1'b0;
        rd_req = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        tick;
        chk("mrst_wr_rdy_back", wr_rdy, 1);
        wr_req = 1'b1;
        repeat (3) tick;
        wr_req = 1'b0;
        #1 chk("mrst_occ_after3", occupancy, 0);
        wr_req = 1'b1;
        tick;
        wr_req = 1'b0;
        #1 chk("mrst_occ_after4", occupancy, 1);
        rd_req = 1'b1;
        repeat (3) tick;
        chk("mrst_drain", occupancy, 0);

        // ---------------- config latch ----------------
        rd_req = 1'b0;
        replay_cfg = 4'd0;
        wr_req = 1'b1;
        repeat (8) tick;
        wr_req = 1'b0;
        #1 chk("cfg_occ2", occupancy, 2);
        replay_cfg = 4'd3;
        rd_req = 1'b1;
        tick;
        chk("cfg_one_pass_done", vec_done, 1);
        tick;
        chk("cfg_occ1", occupancy, 1);
        chk("cfg_idle", rd_valid, 0);
        beats = 0; ptrs = 0; done_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (rd_valid && rd_req) beats++;
            if (fifo_ptr_rst) ptrs++;
            if (vec_done) begin
                done_seen = 1'b1;
                break;
            end
        end
        chk("cfg_done_seen", done_seen, 1);
        chk("cfg_beats", beats, 8);
        chk("cfg_ptrs", ptrs, 3);
        tick;
        chk("cfg_occ0", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_fifo_sched.md
VEC_FIFO_SCHED -- requirements
Module: vec_fifo_sched

Interface
- REQ-001 SHALL have parameter Depth, default 4: vector slots in the managed vector FIFO (>=1).
- REQ-002 SHALL have parameter WritesPerVec, default 4: write beats that complete one vector (>=1).
- REQ-003 SHALL have parameter ReadsPerVec, default 2: read beats per pass over one vector (>=1).
- REQ-004 SHALL have parameter ReplayBits, default 4: width of the replay count.
- REQ-005 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
  - clk_in  input  1  clock; all state updates on the rising edge.
  - rst_in  input  1  asynchronous, active-high reset.
  - wr_req  input  1  producer offers one write beat.
  - wr_rdy  output  1  controller accepts a write beat this cycle.
  - fifo_wr_en  output  1  write strobe to the vector FIFO.
  - rd_req  input  1  consumer takes one read beat.
  - rd_valid  output  1  the read data from the FIFO is valid this cycle.
  - fifo_rd_en  output  1  read-advance strobe to the vector FIFO.
  - fifo_ptr_rst  output  1  rewinds the FIFO read pointer to the start of the current vector.
  - replay_cfg  input  ReplayBits  extra passes per vector; passes = replay_cfg+1.
  - occupancy  output  $clog2(Depth+1)  count of committed, unreleased vectors.
  - vec_done  output  1  one-cycle pulse when a vector is released.

Function
- REQ-006 SHALL drive wr_rdy = (occupancy < Depth).
- REQ-007 SHALL drive fifo_wr_en = wr_req & wr_rdy, combinationally.
- REQ-008 SHALL count accepted write beats in wr_beat, range 0..WritesPerVec-1.
  - On the beat where wr_beat==WritesPerVec-1, wr_beat wraps to 0 and the vector commits: occupancy +1.
- REQ-009 SHALL implement a read FSM with states IDLE, READ, REWIND.
- REQ-010 In IDLE, the FSM SHALL do the following when occupancy>0:
  - latch replay_cfg into passes_left;
  - clear rd_beat;
  - go to READ next cycle.
- REQ-011 In IDLE, rd_valid, fifo_rd_en and fifo_ptr_rst SHALL all be 0.
- REQ-012 In READ, rd_valid SHALL be 1 and fifo_rd_en = rd_req; each accepted beat increments rd_beat.
- REQ-013 On the last beat of a pass (rd_beat==ReadsPerVec-1 & rd_req), the FSM SHALL act as follows:
  - if passes_left>0, go to REWIND and decrement passes_left;
  - otherwise, release the vector: occupancy -1, vec_done=1 the same cycle, go to IDLE.
- REQ-014 REWIND SHALL last exactly one cycle, with the following behaviour:
  - fifo_ptr_rst=1, rd_valid=0, fifo_rd_en=0;
  - rd_beat cleared;
  - go to READ next cycle.
- REQ-015 A commit and a release in the same cycle SHALL leave occupancy unchanged.
- REQ-016 A change to replay_cfg SHALL take effect only at the next IDLE->READ transition.
- REQ-017 The write side SHALL be independent of the read FSM. Writes are accepted during READ and REWIND.
- REQ-018 Latency SHALL be as follows:
  - a vector committed in cycle N gives rd_valid=1 no earlier than cycle N+2 (one cycle registered commit, one IDLE cycle);
  - each release costs one IDLE bubble before the next vector is read.
- REQ-019 occupancy SHALL never exceed Depth and never underflow. In IDLE the FSM leaves only when occupancy>0.
- REQ-020 All outputs SHALL derive from registered state plus wr_req/rd_req. There is no combinational path from replay_cfg to any output.

Reset
- REQ-021 While rst_in=1, asynchronously, the block SHALL hold:
  - state=IDLE;
  - wr_beat=0, rd_beat=0, passes_left=0, occupancy=0;
  - vec_done=0, rd_valid=0, fifo_rd_en=0, fifo_ptr_rst=0, fifo_wr_en=0;
  - wr_rdy=0.
- REQ-022 On the first clock edge after rst_in falls, wr_rdy SHALL be 1.
- REQ-023 A reset asserted mid-vector or mid-pass SHALL discard all partial write and read progress. No vec_done pulse is generated.

Verification (Depth=2, WritesPerVec=4, ReadsPerVec=2)
- REQ-024 Basic vector: 4 write beats with replay_cfg=0 and rd_req held at 1.
  - occupancy goes to 1 after beat 4;
  - IDLE lasts 1 cycle, then rd_valid for 2 cycles;
  - vec_done pulses on the 2nd read beat, occupancy returns to 0.
- REQ-025 Full: 8 write beats with rd_req=0.
  - occupancy=2, wr_rdy=0;
  - a 9th wr_req produces fifo_wr_en=0;
  - wr_rdy returns to 1 in the cycle after the first release.
- REQ-026 Replay: replay_cfg=2, one vector, rd_req=1.
  - read beat sequence is 2, REWIND, 2, REWIND, 2;
  - fifo_ptr_rst pulses exactly twice;
  - vec_done pulses once, after 6 read beats.
- REQ-027 Simultaneous: occupancy=1; the final write beat of vector 2 coincides with the final read beat of vector 1.
  - occupancy stays 1, vec_done=1;
  - the FSM passes through IDLE, then reads vector 2.
- REQ-028 Reset mid-operation: assert rst_in after 2 of 4 write beats and during READ rd_beat=1.
  - all outputs reach their REQ-021 values immediately;
  - after release, 4 new write beats are needed to commit one vector.
- REQ-029 Config latch: replay_cfg changes from 0 to 3 during READ.
  - the current vector is released after one pass;
  - the next vector takes 4 passes.
